// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction prefetcher feeding decode through a small FIFO
module inst_prefetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_neg_i,
  input  logic        rst_neg_ni,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        iram_req_o,
  output logic [31:0] iram_addr_o,
  input  logic        iram_ack_i,
  input  logic [31:0] iram_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc, inflight_pc;
  logic          rst_q, inflight, drop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, occ;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          grant, pop, push;
  // occupancy counts the in-flight word so a response always has a free slot
  assign occ           = count + CW'(inflight);
  assign pop           = instr_valid_o & instr_ready_i;
  assign iram_req_o    = fetch_en_i & ~redirect_i & ~rst_q &
                         ((occ < CW'(DEPTH)) | ((occ == CW'(DEPTH)) & pop));
  assign iram_addr_o   = fetch_pc;
  assign grant         = iram_req_o & iram_ack_i;
  assign push          = inflight & ~drop & ~redirect_i;
  assign instr_valid_o = count != '0;
  assign instr_o       = data_q[rd_ptr];
  assign instr_pc_o    = pc_q[rd_ptr];
  always_ff @(posedge clk_neg_i or negedge rst_neg_ni) begin
    if (!rst_neg_ni) begin
      fetch_pc    <= BOOT_ADDR;
      inflight_pc <= '0;
      rst_q       <= 1'b1;
      inflight    <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      rst_q    <= 1'b0;
      inflight <= grant;
      drop     <= redirect_i & grant;
      if (grant) inflight_pc <= fetch_pc;
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          data_q[wr_ptr] <= iram_rdata_i;
          pc_q[wr_ptr]   <= inflight_pc;
          wr_ptr         <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  count_bound: assert property (@(posedge clk_neg_i) disable iff (!rst_neg_ni) count <= CW'(DEPTH));
endmodule
